pfm_req_sched: RTL and testbench

Request scheduler in front of the prefetch monitor's single table-access port. Buffers the core's decode (PC-signature lookup) and retire (delta training) channels in small per-channel FIFOs and serialises them onto one registered table-op channel. Retire has priority, bounded by a decode anti-starvation counter. Sits between the core-to-pfmonitor interface and the pfmonitor table pipeline.

---
 rtl/pfm_req_sched.sv | 190 +++++++++++++++++++
 tb/tb_pfm_req_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pfm_req_sched.sv
// Request scheduler: two 2-entry FIFOs (decode, retire) serialised onto one registered table-op port.
// Optional grant statistics are built only when PFM_SCHED_STATS_EN is defined.
module pfm_req_sched #(
  parameter int DEC_W      = 24,
  parameter int RET_W      = 80,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  output logic             dec_retry,
  input  logic [DEC_W-1:0] dec_data,
  input  logic             ret_valid,
  output logic             ret_retry,
  input  logic [RET_W-1:0] ret_data,
  output logic             tbl_valid,
  input  logic             tbl_retry,
  output logic             tbl_op,
  output logic [RET_W-1:0] tbl_data,
  output logic [15:0]      stat_dec_grants,
  output logic [15:0]      stat_ret_grants,
  output logic [15:0]      stat_starve
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [DEC_W-1:0] dec_mem_q [2];
  logic [DEC_W-1:0] dec_mem_d [2];
  logic             dec_wp_q, dec_wp_d, dec_rp_q, dec_rp_d;
  logic [1:0]       dec_cnt_q, dec_cnt_d;

  logic [RET_W-1:0] ret_mem_q [2];
  logic [RET_W-1:0] ret_mem_d [2];
  logic             ret_wp_q, ret_wp_d, ret_rp_q, ret_rp_d;
  logic [1:0]       ret_cnt_q, ret_cnt_d;

  logic             tbl_valid_q, tbl_valid_d;
  logic             tbl_op_q, tbl_op_d;
  logic [RET_W-1:0] tbl_data_q, tbl_data_d;
  logic [SW-1:0]    starve_q, starve_d;

  logic dec_push, ret_push, dec_grant, ret_grant, dec_ne, ret_ne, load_en;

  // Retry comes straight from the flopped occupancy, never from valid.
  assign dec_retry = (dec_cnt_q == 2'd2);
  assign ret_retry = (ret_cnt_q == 2'd2);
  assign dec_ne    = (dec_cnt_q != 2'd0);
  assign ret_ne    = (ret_cnt_q != 2'd0);
  assign dec_push  = dec_valid & ~dec_retry;
  assign ret_push  = ret_valid & ~ret_retry;
  assign load_en   = ~tbl_valid_q | ~tbl_retry;

  assign tbl_valid = tbl_valid_q;
  assign tbl_op    = tbl_op_q;
  assign tbl_data  = tbl_data_q;

  always_comb begin
    dec_grant   = 1'b0;
    ret_grant   = 1'b0;
    starve_d    = starve_q;
    tbl_valid_d = tbl_valid_q;
    tbl_op_d    = tbl_op_q;
    tbl_data_d  = tbl_data_q;
    if (load_en) begin
      if (dec_ne && ret_ne) begin
        if (starve_q >= SMAX) dec_grant = 1'b1;
        else                  ret_grant = 1'b1;
      end else if (dec_ne) begin
        dec_grant = 1'b1;
      end else if (ret_ne) begin
        ret_grant = 1'b1;
      end
      tbl_valid_d = dec_grant | ret_grant;
      if (dec_grant) begin
        tbl_op_d   = 1'b0;
        tbl_data_d = RET_W'(dec_mem_q[dec_rp_q]);
        starve_d   = '0;
      end
      if (ret_grant) begin
        tbl_op_d   = 1'b1;
        tbl_data_d = ret_mem_q[ret_rp_q];
        // Only retire wins taken while decode is waiting count toward starvation.
        if (dec_ne) starve_d = starve_q + SW'(1);
      end
    end
  end

  always_comb begin
    dec_mem_d = dec_mem_q;
    dec_wp_d  = dec_wp_q;
    dec_rp_d  = dec_rp_q;
    dec_cnt_d = dec_cnt_q;
    if (dec_push) begin
      dec_mem_d[dec_wp_q] = dec_data;
      dec_wp_d            = ~dec_wp_q;
    end
    if (dec_grant) dec_rp_d = ~dec_rp_q;
    case ({dec_push, dec_grant})
      2'b10:   dec_cnt_d = dec_cnt_q + 2'd1;
      2'b01:   dec_cnt_d = dec_cnt_q - 2'd1;
      default: dec_cnt_d = dec_cnt_q;
    endcase
  end

  always_comb begin
    ret_mem_d = ret_mem_q;
    ret_wp_d  = ret_wp_q;
    ret_rp_d  = ret_rp_q;
    ret_cnt_d = ret_cnt_q;
    if (ret_push) begin
      ret_mem_d[ret_wp_q] = ret_data;
      ret_wp_d            = ~ret_wp_q;
    end
    if (ret_grant) ret_rp_d = ~ret_rp_q;
    case ({ret_push, ret_grant})
      2'b10:   ret_cnt_d = ret_cnt_q + 2'd1;
      2'b01:   ret_cnt_d = ret_cnt_q - 2'd1;
      default: ret_cnt_d = ret_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dec_mem_q   <= '{default: '0};
      dec_wp_q    <= 1'b0;
      dec_rp_q    <= 1'b0;
      dec_cnt_q   <= 2'd0;
      ret_mem_q   <= '{default: '0};
      ret_wp_q    <= 1'b0;
      ret_rp_q    <= 1'b0;
      ret_cnt_q   <= 2'd0;
      tbl_valid_q <= 1'b0;
      tbl_op_q    <= 1'b0;
      tbl_data_q  <= '0;
      starve_q    <= '0;
    end else begin
      dec_mem_q   <= dec_mem_d;
      dec_wp_q    <= dec_wp_d;
      dec_rp_q    <= dec_rp_d;
      dec_cnt_q   <= dec_cnt_d;
      ret_mem_q   <= ret_mem_d;
      ret_wp_q    <= ret_wp_d;
      ret_rp_q    <= ret_rp_d;
      ret_cnt_q   <= ret_cnt_d;
      tbl_valid_q <= tbl_valid_d;
      tbl_op_q    <= tbl_op_d;
      tbl_data_q  <= tbl_data_d;
      starve_q    <= starve_d;
    end
  end

`ifdef PFM_SCHED_STATS_EN
  logic [15:0] stat_dec_q, stat_dec_d, stat_ret_q, stat_ret_d, stat_starve_q, stat_starve_d;
  logic        forced;

  // A decode win while retire is also pending can only be the anti-starvation grant.
  assign forced = dec_grant & ret_ne;

  always_comb begin
    stat_dec_d    = stat_dec_q;
    stat_ret_d    = stat_ret_q;
    stat_starve_d = stat_starve_q;
    if (dec_grant && stat_dec_q != 16'hFFFF)    stat_dec_d    = stat_dec_q + 16'd1;
    if (ret_grant && stat_ret_q != 16'hFFFF)    stat_ret_d    = stat_ret_q + 16'd1;
    if (forced && stat_starve_q != 16'hFFFF)    stat_starve_d = stat_starve_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_dec_q    <= 16'd0;
      stat_ret_q    <= 16'd0;
      stat_starve_q <= 16'd0;
    end else begin
      stat_dec_q    <= stat_dec_d;
      stat_ret_q    <= stat_ret_d;
      stat_starve_q <= stat_starve_d;
    end
  end

  assign stat_dec_grants = stat_dec_q;
  assign stat_ret_grants = stat_ret_q;
  assign stat_starve     = stat_starve_q;
`else
  assign stat_dec_grants = 16'd0;
  assign stat_ret_grants = 16'd0;
  assign stat_starve     = 16'd0;
`endif

endmodule

// File: tb/tb_pfm_req_sched.sv
// Self-checking bench for pfm_req_sched: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pfm_req_sched;
  localparam int DEC_W      = 24;
  localparam int RET_W      = 80;
  localparam int STARVE_MAX = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             dec_valid = 1'b0;
  logic             dec_retry;
  logic [DEC_W-1:0] dec_data = '0;
  logic             ret_valid = 1'b0;
  logic             ret_retry;
  logic [RET_W-1:0] ret_data = '0;
  logic             tbl_valid;
  logic             tbl_retry = 1'b0;
  logic             tbl_op;
  logic [RET_W-1:0] tbl_data;
  logic [15:0]      stat_dec_grants, stat_ret_grants, stat_starve;

  pfm_req_sched #(.DEC_W(DEC_W), .RET_W(RET_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_retry(dec_retry), .dec_data(dec_data),
    .ret_valid(ret_valid), .ret_retry(ret_retry), .ret_data(ret_data),
    .tbl_valid(tbl_valid), .tbl_retry(tbl_retry), .tbl_op(tbl_op), .tbl_data(tbl_data),
    .stat_dec_grants(stat_dec_grants), .stat_ret_grants(stat_ret_grants), .stat_starve(stat_starve)
  );

  always #5 clk = ~clk;

  int assert_count = 0;
  int fail_count   = 0;
  bit check_en     = 1'b1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic dv, input logic [DEC_W-1:0] dd,
                               input logic rv, input logic [RET_W-1:0] rd, input logic tr);
    dec_valid = dv;
    dec_data  = dd;
    ret_valid = rv;
    ret_data  = rd;
    tbl_retry = tr;
    @(negedge clk);
  endtask

  // Reference model: channel FIFOs as queues, output register as plain variables.
  logic [DEC_W-1:0] m_dq[$];
  logic [RET_W-1:0] m_rq[$];
  bit               m_valid, m_op, m_pd, m_pr;
  logic [RET_W-1:0] m_data;
  int               m_starve, m_sd, m_sr, m_ss;

  always @(posedge clk) begin
    if (!reset) begin
      m_dq.delete();
      m_rq.delete();
      m_valid = 0; m_op = 0; m_data = '0;
      m_starve = 0; m_sd = 0; m_sr = 0; m_ss = 0;
    end else begin
      m_pd = dec_valid && (m_dq.size() < 2);
      m_pr = ret_valid && (m_rq.size() < 2);
      if (!m_valid || !tbl_retry) begin
        if (m_dq.size() > 0 && m_rq.size() > 0 && m_starve >= STARVE_MAX) begin
          m_valid = 1; m_op = 0; m_data = RET_W'(m_dq.pop_front());
          m_starve = 0;
          if (m_sd < 65535) m_sd++;
          if (m_ss < 65535) m_ss++;
        end else if (m_dq.size() > 0 && m_rq.size() > 0) begin
          m_valid = 1; m_op = 1; m_data = m_rq.pop_front();
          m_starve++;
          if (m_sr < 65535) m_sr++;
        end else if (m_dq.size() > 0) begin
          m_valid = 1; m_op = 0; m_data = RET_W'(m_dq.pop_front());
          m_starve = 0;
          if (m_sd < 65535) m_sd++;
        end else if (m_rq.size() > 0) begin
          m_valid = 1; m_op = 1; m_data = m_rq.pop_front();
          if (m_sr < 65535) m_sr++;
        end else begin
          m_valid = 0;
        end
      end
      if (m_pd) m_dq.push_back(dec_data);
      if (m_pr) m_rq.push_back(ret_data);
    end
  end

  logic [15:0] e_sd, e_sr, e_ss;
  always @(negedge clk) begin
    if (check_en) begin
`ifdef PFM_SCHED_STATS_EN
      e_sd = 16'(m_sd); e_sr = 16'(m_sr); e_ss = 16'(m_ss);
`else
      e_sd = 16'd0; e_sr = 16'd0; e_ss = 16'd0;
`endif
      checkOutput("m_tbl_valid", 128'(tbl_valid), 128'(m_valid));
      checkOutput("m_tbl_op", 128'(tbl_op), 128'(m_op));
      checkOutput("m_tbl_data", 128'(tbl_data), 128'(m_data));
      checkOutput("m_dec_retry", 128'(dec_retry), 128'(m_dq.size() == 2));
      checkOutput("m_ret_retry", 128'(ret_retry), 128'(m_rq.size() == 2));
      checkOutput("m_stat_dec", 128'(stat_dec_grants), 128'(e_sd));
      checkOutput("m_stat_ret", 128'(stat_ret_grants), 128'(e_sr));
      checkOutput("m_stat_starve", 128'(stat_starve), 128'(e_ss));
    end
  end

  bit               exp_ops [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [DEC_W-1:0] bp_items [4] = '{24'h00000A, 24'h00000B, 24'h00000C, 24'h00000D};
  logic [RET_W-1:0] got[$];
  logic [RET_W-1:0] got_val;
  int               idx;
  bit               acc, tr;

  initial begin
    $display("[TB] start");
    // Reset held with both channels requesting.
    reset = 1'b0;
    applyStimulus(1'b1, 24'h111111, 1'b1, 80'h2222, 1'b0);
    applyStimulus(1'b1, 24'h111111, 1'b1, 80'h2222, 1'b0);
    checkOutput("rst_tbl_valid", 128'(tbl_valid), 128'd0);
    checkOutput("rst_dec_retry", 128'(dec_retry), 128'd0);
    checkOutput("rst_ret_retry", 128'(ret_retry), 128'd0);
    checkOutput("rst_stat_dec", 128'(stat_dec_grants), 128'd0);
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("rst_nothing_accepted", 128'(tbl_valid), 128'd0);

    // Single decode: two-cycle latency, zero-extended payload.
    applyStimulus(1'b1, 24'h00ABCD, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("single_valid", 128'(tbl_valid), 128'd1);
    checkOutput("single_op", 128'(tbl_op), 128'd0);
    checkOutput("single_data", 128'(tbl_data), 128'h00ABCD);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("single_valid_clear", 128'(tbl_valid), 128'd0);

    // Contention: R,R,R,D repeating.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 24'hD00000 | 24'(i), 1'b1, 80'hE000 | 80'(i), 1'b0);
      if (i >= 1) begin
        checkOutput("cont_valid", 128'(tbl_valid), 128'd1);
        checkOutput("cont_op", 128'(tbl_op), 128'(exp_ops[i-1]));
      end
    end
`ifdef PFM_SCHED_STATS_EN
    checkOutput("cont_starve", 128'(stat_starve), 128'd2);
`else
    checkOutput("cont_starve", 128'(stat_starve), 128'd0);
`endif
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);

    // Backpressure: decode pushes A..D while the table port stalls.
    idx = 0;
    for (int i = 0; i < 14; i++) begin
      tr = (i < 6);
      if (tbl_valid && !tr) got.push_back(tbl_data);
      acc = (idx < 4) && !dec_retry;
      applyStimulus(idx < 4, bp_items[(idx < 4) ? idx : 3], 1'b0, '0, tr);
      if (acc) idx++;
      if (i >= 1 && i <= 5) checkOutput("bp_hold_a", 128'(tbl_data), 128'h0A);
      if (i == 2) checkOutput("bp_dec_retry", 128'(dec_retry), 128'd1);
    end
    checkOutput("bp_count", 128'(got.size()), 128'd4);
    for (int k = 0; k < 4; k++) begin
      got_val = (k < got.size()) ? got[k] : '1;
      checkOutput("bp_order", 128'(got_val), 128'(RET_W'(bp_items[k])));
    end

    // Reset mid-operation with both FIFOs full and an op held.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 24'h0000F1, 1'b1, 80'hF2, 1'b1);
    checkOutput("mid_setup_dec_full", 128'(dec_retry), 128'd1);
    checkOutput("mid_setup_ret_full", 128'(ret_retry), 128'd1);
    checkOutput("mid_setup_valid", 128'(tbl_valid), 128'd1);
    reset = 1'b0;
    applyStimulus(1'b1, 24'h0000F1, 1'b1, 80'hF2, 1'b1);
    checkOutput("mid_rst_valid", 128'(tbl_valid), 128'd0);
    checkOutput("mid_rst_op", 128'(tbl_op), 128'd0);
    checkOutput("mid_rst_data", 128'(tbl_data), 128'd0);
    checkOutput("mid_rst_dec_retry", 128'(dec_retry), 128'd0);
    checkOutput("mid_rst_ret_retry", 128'(ret_retry), 128'd0);
    checkOutput("mid_rst_stat_ret", 128'(stat_ret_grants), 128'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("mid_no_replay", 128'(tbl_valid), 128'd0);
    applyStimulus(1'b0, '0, 1'b1, 80'hFEED, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("mid_new_valid", 128'(tbl_valid), 128'd1);
    checkOutput("mid_new_op", 128'(tbl_op), 128'd1);
    checkOutput("mid_new_data", 128'(tbl_data), 128'hFEED);

    // Stats: 10 retire then 4 decode requests, no contention.
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1, 80'h300 | 80'(i), 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 24'h400 | 24'(i), 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
`ifdef PFM_SCHED_STATS_EN
    checkOutput("stats_ret", 128'(stat_ret_grants), 128'd10);
    checkOutput("stats_dec", 128'(stat_dec_grants), 128'd4);
`else
    checkOutput("stats_ret", 128'(stat_ret_grants), 128'd0);
    checkOutput("stats_dec", 128'(stat_dec_grants), 128'd0);
`endif
    checkOutput("stats_starve", 128'(stat_starve), 128'd0);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
